// File: rtl/mux_select_sequencer.sv
// mux_select_sequencer
//   Drives the 3-bit select of an 8-to-1 data mux. It scans the enabled
//   channels in ascending order and holds each one for a programmable dwell.
//   Each pass over the enabled channels is a frame, and frame boundaries are
//   flagged with pulses. Scanning runs for a single frame or continuously.
//   A scan can be aborted at any time.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   start       single-cycle request to begin scanning (ignored while busy)
//   stop        single-cycle abort; takes priority over start and end-of-frame
//   mode        1 = continuous, 0 = one frame; sampled at end-of-frame
//   ch_en       per-channel enable mask, snapshotted at frame boundaries
//   dwell       cycles per channel (0 behaves as 1), snapshotted with ch_en
//   s           registered mux select
//   sel_valid   s addresses a live channel
//   frame_start pulse on the first cycle of a frame
//   frame_done  pulse on the last cycle of a frame (suppressed by stop)
//   busy        scanning
//   no_ch       pulse when a frame could not start because the mask was zero
module mux_select_sequencer #(
  parameter int N_CH    = 8,
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [N_CH-1:0]    ch_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   s,
  output logic               sel_valid,
  output logic               frame_start,
  output logic               frame_done,
  output logic               busy,
  output logic               no_ch
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t             r_state, w_state_next;
  logic [SEL_W-1:0]   r_s, w_s_next;
  logic [DWELL_W-1:0] r_cnt, w_cnt_next;
  logic [N_CH-1:0]    r_en_q, w_en_next;
  logic [DWELL_W-1:0] r_dw_q, w_dw_next;
  logic               r_frame_start, w_frame_start_next;
  logic               r_no_ch, w_no_ch_next;
  logic               r_fd_la, w_fd_la_next;
  logic               r_sel_valid, r_busy;

  logic [DWELL_W-1:0] w_dwell_eff;
  logic [N_CH-1:0]    w_above;
  logic               w_has_higher;
  logic [SEL_W-1:0]   w_next_higher;
  logic               w_last_dwell;

  // Lowest set bit of a mask (0 when the mask is empty).
  function automatic logic [SEL_W-1:0] lowest_bit(input logic [N_CH-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // True when the mask has any set bit strictly above pos.
  function automatic logic any_above(input logic [N_CH-1:0] m, input logic [SEL_W-1:0] pos);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (m[i] && (SEL_W'(i) > pos)) r = 1'b1;
    end
    return r;
  endfunction

  assign w_dwell_eff  = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign w_last_dwell = (r_cnt <= DWELL_W'(1));

  // Channels of the frame snapshot that still lie ahead of the current select.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_above
      assign w_above[gi] = r_en_q[gi] && (SEL_W'(gi) > r_s);
    end
  endgenerate

  assign w_has_higher  = |w_above;
  assign w_next_higher = lowest_bit(w_above);

  // State register (plus datapath registers that move with it).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_s           <= '0;
      r_cnt         <= '0;
      r_en_q        <= '0;
      r_dw_q        <= '0;
      r_frame_start <= 1'b0;
      r_no_ch       <= 1'b0;
      r_fd_la       <= 1'b0;
      r_sel_valid   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_s           <= w_s_next;
      r_cnt         <= w_cnt_next;
      r_en_q        <= w_en_next;
      r_dw_q        <= w_dw_next;
      r_frame_start <= w_frame_start_next;
      r_no_ch       <= w_no_ch_next;
      r_fd_la       <= w_fd_la_next;
      r_sel_valid   <= (w_state_next == SCAN);
      r_busy        <= (w_state_next == SCAN);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next       = r_state;
    w_s_next           = r_s;
    w_cnt_next         = r_cnt;
    w_en_next          = r_en_q;
    w_dw_next          = r_dw_q;
    w_frame_start_next = 1'b0;
    w_no_ch_next       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start && !stop) begin
          w_en_next = ch_en;
          w_dw_next = w_dwell_eff;
          if (ch_en != '0) begin
            w_state_next       = SCAN;
            w_s_next           = lowest_bit(ch_en);
            w_cnt_next         = w_dwell_eff;
            w_frame_start_next = 1'b1;
          end else begin
            w_no_ch_next = 1'b1;
          end
        end
      end
      SCAN: begin
        if (stop) begin
          w_state_next = IDLE;
        end else if (!w_last_dwell) begin
          w_cnt_next = r_cnt - DWELL_W'(1);
        end else if (w_has_higher) begin
          w_s_next   = w_next_higher;
          w_cnt_next = r_dw_q;
        end else if (!mode) begin
          w_state_next = IDLE;
        end else begin
          // Continuous: the next frame begins with a fresh snapshot, no gap.
          w_en_next = ch_en;
          w_dw_next = w_dwell_eff;
          if (ch_en != '0) begin
            w_s_next           = lowest_bit(ch_en);
            w_cnt_next         = w_dwell_eff;
            w_frame_start_next = 1'b1;
          end else begin
            w_state_next = IDLE;
            w_no_ch_next = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Look-ahead: the coming cycle is the final dwell cycle of the final
  // channel. Registering this keeps frame_done off the long select path.
  assign w_fd_la_next = (w_state_next == SCAN) && (w_cnt_next == DWELL_W'(1)) &&
                        !any_above(w_en_next, w_s_next);

  // Output logic. Only frame_done sees an input directly, so that an abort
  // on the final cycle cancels the pulse.
  always_comb begin
    s           = r_s;
    sel_valid   = r_sel_valid;
    busy        = r_busy;
    frame_start = r_frame_start;
    no_ch       = r_no_ch;
    frame_done  = r_fd_la && !stop;
  end

endmodule

// File: tb/tb_mux_select_sequencer.sv
module tb_mux_select_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, mode;
  logic [7:0] ch_en;
  logic [3:0] dwell;
  logic [2:0] s;
  logic       sel_valid, frame_start, frame_done, busy, no_ch;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a frame is the list of selects it will present, one
  // entry per cycle. The queue front is the current cycle.
  int q[$];
  bit m_busy;
  bit m_fs;
  bit m_noch;
  int m_last_s;

  mux_select_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .ch_en(ch_en), .dwell(dwell), .s(s), .sel_valid(sel_valid),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy), .no_ch(no_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy   = 0;
    m_fs     = 0;
    m_noch   = 0;
    m_last_s = 0;
  endtask

  task automatic build_frame(input logic [7:0] en, input logic [3:0] dw);
    int d;
    d = (dw == 0) ? 1 : int'(dw);
    q.delete();
    for (int ch = 0; ch < 8; ch++)
      if (en[ch]) for (int k = 0; k < d; k++) q.push_back(ch);
  endtask

  // One clock cycle: drive inputs, check every output, advance the model.
  task automatic step(input logic st, input logic sp, input logic md,
                      input logic [7:0] en, input logic [3:0] dw);
    int exp_s;
    bit exp_fd;
    int popped;
    @(negedge clk);
    start = st; stop = sp; mode = md; ch_en = en; dwell = dw;
    #1;
    exp_s  = m_busy ? q[0] : m_last_s;
    exp_fd = m_busy && (q.size() == 1) && !sp;
    chk("s", 32'(s), 32'(exp_s));
    chk("sel_valid", 32'(sel_valid), 32'(m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    chk("no_ch", 32'(no_ch), 32'(m_noch));
    $display("cyc t=%0t st=%0b sp=%0b md=%0b en=%02h dw=%0d | s=%0d v=%0b fs=%0b fd=%0b busy=%0b noch=%0b",
             $time, st, sp, md, en, dw, s, sel_valid, frame_start, frame_done, busy, no_ch);
    m_fs   = 0;
    m_noch = 0;
    if (!m_busy) begin
      if (st && !sp) begin
        if (en == 0) m_noch = 1;
        else begin
          build_frame(en, dw);
          m_busy = 1;
          m_fs   = 1;
        end
      end
    end else if (sp) begin
      m_last_s = q[0];
      q.delete();
      m_busy = 0;
    end else begin
      popped = q.pop_front();
      if (q.size() == 0) begin
        m_last_s = popped;
        if (md && en != 0) begin
          build_frame(en, dw);
          m_fs = 1;
        end else begin
          m_busy = 0;
          if (md) m_noch = 1;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 0; stop = 0; mode = 0; ch_en = 0; dwell = 0;
    model_reset();
    #12;
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Full mask, dwell 1, single frame.
    step(1, 0, 0, 8'hFF, 4'd1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 8'hFF, 4'd1);

    // Sparse mask, dwell 3, continuous, then stop.
    step(1, 0, 1, 8'b1010_0100, 4'd3);
    for (int i = 0; i < 22; i++) step(0, 0, 1, 8'b1010_0100, 4'd3);
    step(0, 1, 1, 8'b1010_0100, 4'd3);
    step(0, 0, 1, 8'b1010_0100, 4'd3);

    // Empty mask.
    step(1, 0, 0, 8'h00, 4'd2);
    step(0, 0, 0, 8'h00, 4'd2);
    step(0, 0, 0, 8'h00, 4'd2);

    // Mask changes mid-frame take effect at the boundary.
    step(1, 0, 1, 8'h0F, 4'd1);
    step(0, 0, 1, 8'h0F, 4'd1);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'h80, 4'd1);
    step(0, 1, 1, 8'h80, 4'd1);

    // Dwell 0 on one channel: start and done every cycle; stop on cycle 5.
    step(1, 0, 1, 8'h10, 4'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h10, 4'd0);
    step(0, 1, 1, 8'h10, 4'd0);
    step(0, 0, 1, 8'h10, 4'd0);
    // stop beats start in IDLE
    step(1, 1, 1, 8'h10, 4'd0);
    step(0, 0, 1, 8'h10, 4'd0);

    // Asynchronous reset mid-scan with s = 5.
    step(1, 0, 1, 8'h20, 4'd4);
    step(0, 0, 1, 8'h20, 4'd4);
    @(negedge clk);
    start = 0; stop = 0;
    #1;
    chk("pre_rst_s", 32'(s), 32'd5);
    reset = 1'b1;
    #1;
    chk("arst_s", 32'(s), 32'd0);
    chk("arst_sel_valid", 32'(sel_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_frame_done", 32'(frame_done), 32'd0);
    #1;
    reset = 1'b0;
    model_reset();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic       st, sp, md;
      logic [7:0] en;
      logic [3:0] dw;
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 24) == 0);
      md = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      dw = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      step(st, sp, md, en, dw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
